// File: rtl/regdst_pipe_if.sv
// regdst_pipe_if: issue/decode-side bundle for regdst_pipe.
//  master: drives the issue slot, stall/flush and the decode source operands.
//  slave : the regdst_pipe block. It returns the selected destination, the
//          last-stage entry, the RAW match vectors and the sticky mode error.
//  AW    register-address width
//  DEPTH pipeline stages after selection. This sets the hazard vector width.
interface regdst_pipe_if #(
  parameter int AW    = 5,
  parameter int DEPTH = 2
);
  logic          in_valid;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [1:0]    sel_mode;
  logic          reg_write;
  logic          stall;
  logic          flush;
  logic [AW-1:0] src_a;
  logic [AW-1:0] src_b;

  logic [AW-1:0]    sel_dst;
  logic             out_valid;
  logic [AW-1:0]    out_dst;
  logic             out_we;
  logic [DEPTH-1:0] hazard_a;
  logic [DEPTH-1:0] hazard_b;
  logic             mode_err;

  modport master (
    output in_valid, rt, rd, sel_mode, reg_write, stall, flush, src_a, src_b,
    input  sel_dst, out_valid, out_dst, out_we, hazard_a, hazard_b, mode_err
  );

  modport slave (
    input  in_valid, rt, rd, sel_mode, reg_write, stall, flush, src_a, src_b,
    output sel_dst, out_valid, out_dst, out_we, hazard_a, hazard_b, mode_err
  );
endinterface

// File: rtl/regdst_pipe.sv
// regdst_pipe: selects the write-back register and tracks destinations.
//  The block picks the write-back register (rt, rd or link) for the issued
//  instruction. It carries {valid, dst, we} through DEPTH registered stages
//  with stall and flush. It exposes per-stage RAW match vectors for the
//  forwarding and hazard logic.
//  Ports:
//   clk   rising-edge clock
//   rst_n synchronous reset, active-low
//   bus   regdst_pipe_if.slave, which carries:
//         in:  in_valid, rt, rd, sel_mode, reg_write, stall, flush, src_a, src_b
//         out: sel_dst, out_valid, out_dst, out_we, hazard_a, hazard_b, mode_err
//  Parameters:
//   AW            register-address width
//   DEPTH         stages after selection, 1..4
//   LINK_REG      destination address used in link mode
//   ZERO_SUPPRESS when nonzero, address 0 is never written and never matches
module regdst_pipe #(
  parameter int AW            = 5,
  parameter int DEPTH         = 2,
  parameter int LINK_REG      = 31,
  parameter int ZERO_SUPPRESS = 1
)(
  input logic         clk,
  input logic         rst_n,
  regdst_pipe_if.slave bus
);

  if (DEPTH < 1 || DEPTH > 4) begin : g_bad_depth
    $error("regdst_pipe: DEPTH must be in 1..4");
  end

  localparam logic [AW-1:0] LINK_DST = AW'(LINK_REG);
  localparam bit            ZS       = (ZERO_SUPPRESS != 0);

  localparam logic [1:0] MODE_RT   = 2'b00;
  localparam logic [1:0] MODE_RD   = 2'b01;
  localparam logic [1:0] MODE_LINK = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

  // Stage k sits at index k. Stage 0 is the combinational issue slot, so it
  // is not stored here.
  logic [DEPTH:1]         vld_pipe;
  logic [DEPTH:1]         we_pipe;
  logic [DEPTH:1][AW-1:0] dst_pipe;

  logic [AW-1:0]    sel;
  logic             we0;
  logic             advance;
  logic             mode_err_q;
  logic [DEPTH-1:0] haz_a;
  logic [DEPTH-1:0] haz_b;

  // Destination select. The reserved mode falls back to rt, and mode_err
  // flags it.
  always_comb begin
    sel = bus.rt;
    case (bus.sel_mode)
      MODE_RD:   sel = bus.rd;
      MODE_LINK: sel = LINK_DST;
      default:   sel = bus.rt;
    endcase
  end

  // The write enable is qualified once, here. Downstream stages and the
  // hazard compare can then trust we as-is.
  assign we0     = bus.in_valid & bus.reg_write & ~(ZS & (sel == '0));
  assign advance = ~bus.flush & ~bus.stall;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      we_pipe    <= '0;
      dst_pipe   <= '0;
      mode_err_q <= 1'b0;
    end else if (bus.flush) begin
      // Flush wins over stall. dst may stay stale because valid/we gate it.
      vld_pipe <= '0;
      we_pipe  <= '0;
    end else if (!bus.stall) begin
      for (int k = DEPTH; k >= 2; k--) begin
        vld_pipe[k] <= vld_pipe[k-1];
        we_pipe[k]  <= we_pipe[k-1];
        dst_pipe[k] <= dst_pipe[k-1];
      end
      vld_pipe[1] <= bus.in_valid;
      we_pipe[1]  <= we0;
      dst_pipe[1] <= sel;
    end
    // mode_err is only set when the reserved encoding is actually accepted
    // into the pipe.
    if (rst_n && advance && bus.in_valid && (bus.sel_mode == MODE_RSVD))
      mode_err_q <= 1'b1;
  end

  // RAW match against registered contents. Bit 0 is the youngest stage.
  // During a stall the held contents still produce matches.
  always_comb begin
    haz_a = '0;
    haz_b = '0;
    for (int k = 0; k < DEPTH; k++) begin
      haz_a[k] = vld_pipe[k+1] & we_pipe[k+1] & (dst_pipe[k+1] == bus.src_a)
                 & ~(ZS & (bus.src_a == '0));
      haz_b[k] = vld_pipe[k+1] & we_pipe[k+1] & (dst_pipe[k+1] == bus.src_b)
                 & ~(ZS & (bus.src_b == '0));
    end
  end

  assign bus.sel_dst   = sel;
  assign bus.out_valid = vld_pipe[DEPTH];
  assign bus.out_dst   = dst_pipe[DEPTH];
  assign bus.out_we    = we_pipe[DEPTH];
  assign bus.hazard_a  = haz_a;
  assign bus.hazard_b  = haz_b;
  assign bus.mode_err  = mode_err_q;

endmodule

// File: tb/tb_regdst_pipe.sv
// Bench for regdst_pipe (AW=5, DEPTH=2, LINK_REG=31, ZERO_SUPPRESS=1).
// The bench drives inputs 1 time unit after each rising edge and runs its
// scoreboard on the falling edge.
module tb_regdst_pipe;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  regdst_pipe_if #(.AW(AW), .DEPTH(DEPTH)) bus ();

  regdst_pipe #(.AW(AW), .DEPTH(DEPTH), .LINK_REG(31), .ZERO_SUPPRESS(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [AW-1:0] dst;
    logic          we;
  } exp_t;

  typedef struct {
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [1:0]    mode;
    logic          rw;
    logic [AW-1:0] sel;
    logic          we;
  } vec_t;

  exp_t sb_q[$];
  exp_t exp_in;
  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [AW-1:0] rt_i, input logic [AW-1:0] rd_i,
                       input logic [1:0] m, input logic rw,
                       input logic [AW-1:0] ed, input logic ew);
    bus.in_valid  = v;
    bus.rt        = rt_i;
    bus.rd        = rd_i;
    bus.sel_mode  = m;
    bus.reg_write = rw;
    exp_in        = '{dst: ed, we: ew};
  endtask

  task automatic idle();
    drive(1'b0, '0, '0, 2'b00, 1'b0, '0, 1'b0);
  endtask

  // Scoreboard. An entry is pushed when the issue slot is accepted. It is
  // popped when the last stage hands it on. Flush and reset drop everything
  // in flight.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n || bus.flush) begin
      sb_q.delete();
    end else if (!bus.stall) begin
      if (bus.out_valid) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_empty: out_valid=1 dst=%0d but no entry expected", bus.out_dst);
        end else begin
          e = sb_q.pop_front();
          chk("sb_dst", 32'(bus.out_dst), 32'(e.dst));
          chk("sb_we", 32'(bus.out_we), 32'(e.we));
        end
      end
      if (bus.in_valid) sb_q.push_back(exp_in);
    end
  end

  initial begin
    vt[0] = '{5'd3,  5'd9,  2'b00, 1'b1, 5'd3,  1'b1};
    vt[1] = '{5'd3,  5'd9,  2'b01, 1'b1, 5'd9,  1'b1};
    vt[2] = '{5'd3,  5'd9,  2'b10, 1'b1, 5'd31, 1'b1};
    vt[3] = '{5'd0,  5'd9,  2'b00, 1'b1, 5'd0,  1'b0};
    vt[4] = '{5'd5,  5'd0,  2'b01, 1'b1, 5'd0,  1'b0};
    vt[5] = '{5'd6,  5'd7,  2'b01, 1'b0, 5'd7,  1'b0};
    vt[6] = '{5'd12, 5'd20, 2'b10, 1'b0, 5'd31, 1'b0};
    vt[7] = '{5'd17, 5'd2,  2'b00, 1'b1, 5'd17, 1'b1};

    bus.stall = 1'b0;
    bus.flush = 1'b0;
    bus.src_a = '0;
    bus.src_b = '0;
    idle();

    // Reset held for two edges.
    rst_n = 1'b0;
    step();
    step();
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_dst", 32'(bus.out_dst), 0);
    chk("rst_out_we", 32'(bus.out_we), 0);
    chk("rst_hazard_a", 32'(bus.hazard_a), 0);
    chk("rst_hazard_b", 32'(bus.hazard_b), 0);
    chk("rst_mode_err", 32'(bus.mode_err), 0);
    rst_n = 1'b1;

    // Latency: rd=9 issued at cycle 0 appears at the output at cycle 2.
    drive(1'b1, 5'd0, 5'd9, 2'b01, 1'b1, 5'd9, 1'b1);
    step();
    idle();
    bus.src_a = 5'd9;
    #1;
    chk("lat_c1_out_valid", 32'(bus.out_valid), 0);
    chk("lat_c1_hazard_a", 32'(bus.hazard_a), 32'b01);
    step();
    chk("lat_c2_out_valid", 32'(bus.out_valid), 1);
    chk("lat_c2_out_dst", 32'(bus.out_dst), 9);
    chk("lat_c2_out_we", 32'(bus.out_we), 1);
    chk("lat_c2_hazard_a", 32'(bus.hazard_a), 32'b10);
    bus.src_a = '0;

    // Selection table applied back to back. The scoreboard checks what
    // comes out of the pipe.
    foreach (vt[i]) begin
      drive(1'b1, vt[i].rt, vt[i].rd, vt[i].mode, vt[i].rw, vt[i].sel, vt[i].we);
      #1;
      chk($sformatf("tbl_sel[%0d]", i), 32'(bus.sel_dst), 32'(vt[i].sel));
      step();
    end
    idle();
    repeat (DEPTH + 1) step();
    chk("tbl_drain", sb_q.size(), 0);

    // A write to r0 never matches src_a=0 at any stage.
    bus.src_a = '0;
    drive(1'b1, 5'd0, 5'd4, 2'b00, 1'b1, 5'd0, 1'b0);
    step();
    idle();
    for (int c = 0; c < DEPTH; c++) begin
      chk($sformatf("zero_haz_a[%0d]", c), 32'(bus.hazard_a), 0);
      step();
    end

    // Stall for two cycles with dst 3, 4, 5 in flight.
    bus.src_a = 5'd4;
    bus.src_b = 5'd3;
    drive(1'b1, 5'd0, 5'd3, 2'b01, 1'b1, 5'd3, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd4, 2'b01, 1'b1, 5'd4, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd5, 2'b01, 1'b1, 5'd5, 1'b1);
    bus.stall = 1'b1;
    #1;
    chk("stall_pre_haz_a", 32'(bus.hazard_a), 32'b01);
    chk("stall_pre_haz_b", 32'(bus.hazard_b), 32'b10);
    for (int c = 0; c < 2; c++) begin
      step();
      chk($sformatf("stall_haz_a[%0d]", c), 32'(bus.hazard_a), 32'b01);
      chk($sformatf("stall_haz_b[%0d]", c), 32'(bus.hazard_b), 32'b10);
      chk($sformatf("stall_out_dst[%0d]", c), 32'(bus.out_dst), 3);
    end
    bus.stall = 1'b0;
    step();
    chk("stall_rel_haz_a", 32'(bus.hazard_a), 32'b10);
    chk("stall_rel_out_dst", 32'(bus.out_dst), 4);
    idle();
    repeat (DEPTH + 1) step();
    chk("stall_drain", sb_q.size(), 0);

    // Flush and stall together, with two entries in flight. The input
    // presented in the flush cycle is discarded.
    drive(1'b1, 5'd0, 5'd10, 2'b01, 1'b1, 5'd10, 1'b1);
    step();
    drive(1'b1, 5'd0, 5'd11, 2'b01, 1'b1, 5'd11, 1'b1);
    step();
    bus.src_a = 5'd11;
    bus.src_b = 5'd10;
    drive(1'b1, 5'd0, 5'd12, 2'b01, 1'b1, 5'd12, 1'b1);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    #1;
    chk("flush_pre_haz_a", 32'(bus.hazard_a), 32'b01);
    step();
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    idle();
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_out_we", 32'(bus.out_we), 0);
    chk("flush_haz_a", 32'(bus.hazard_a), 0);
    chk("flush_haz_b", 32'(bus.hazard_b), 0);
    bus.src_a = 5'd12;
    #1;
    chk("flush_discard_haz", 32'(bus.hazard_a), 0);
    for (int c = 0; c < DEPTH; c++) begin
      step();
      chk($sformatf("flush_after_valid[%0d]", c), 32'(bus.out_valid), 0);
    end

    // Reserved mode: ignored while stalled, sticky once accepted, and
    // cleared only by reset.
    bus.src_a = '0;
    bus.src_b = '0;
    drive(1'b1, 5'd7, 5'd1, 2'b11, 1'b1, 5'd7, 1'b1);
    bus.stall = 1'b1;
    #1;
    chk("rsvd_sel_dst", 32'(bus.sel_dst), 7);
    step();
    chk("rsvd_stall_mode_err", 32'(bus.mode_err), 0);
    bus.stall = 1'b0;
    step();
    chk("rsvd_mode_err_set", 32'(bus.mode_err), 1);
    idle();
    repeat (DEPTH + 1) step();
    chk("rsvd_mode_err_sticky", 32'(bus.mode_err), 1);
    chk("rsvd_drain", sb_q.size(), 0);

    // Reset mid-stream drops the in-flight entry and clears mode_err.
    drive(1'b1, 5'd0, 5'd13, 2'b01, 1'b1, 5'd13, 1'b1);
    step();
    idle();
    rst_n = 1'b0;
    step();
    chk("rst2_mode_err", 32'(bus.mode_err), 0);
    chk("rst2_out_valid", 32'(bus.out_valid), 0);
    rst_n = 1'b1;
    for (int c = 0; c < DEPTH + 1; c++) begin
      step();
      chk($sformatf("rst2_after_valid[%0d]", c), 32'(bus.out_valid), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
